// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets and integrates their deltas into a
// clamped absolute cursor position with button state and an update strobe.
module mouse_pos_tracker #(
  parameter int XMAX        = 799,
  parameter int YMAX        = 599,
  parameter int XINIT       = 400,
  parameter int YINIT       = 300,
  parameter int TIMEOUT_CYC = 80000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        pos_update
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, APPLY} state_t;

  // Only the header bits that influence the outputs are kept.
  typedef struct packed {
    logic ovf_y;
    logic ovf_x;
    logic sign_y;
    logic sign_x;
    logic btn_r;
    logic btn_l;
  } hdr_t;

  state_t          r_state, w_state_next;
  hdr_t            r_hdr, w_hdr_next;
  logic [7:0]      r_b1, w_b1_next;
  logic [7:0]      r_b2, w_b2_next;
  logic [TW-1:0]   r_timer, w_timer_next;
  logic [11:0]     r_xpos, w_xpos_next;
  logic [11:0]     r_ypos, w_ypos_next;
  logic            r_left, w_left_next;
  logic            r_right, w_right_next;
  logic            r_pos_update, w_pos_update_next;

  logic            w_sync;
  hdr_t            w_hdr_in;
  logic [8:0]      w_dx, w_dy;
  logic [13:0]     w_nx, w_ny;
  logic [11:0]     w_x_clamped, w_y_clamped;

  assign w_sync   = rx_valid & rx_data[3];
  assign w_hdr_in = '{ovf_y: rx_data[7], ovf_x: rx_data[6], sign_y: rx_data[5],
                      sign_x: rx_data[4], btn_r: rx_data[1], btn_l: rx_data[0]};

  assign w_dx = r_hdr.ovf_x ? 9'd0 : {r_hdr.sign_x, r_b1};
  assign w_dy = r_hdr.ovf_y ? 9'd0 : {r_hdr.sign_y, r_b2};

  // PS/2 positive y is upward, screen y grows downward.
  assign w_nx = {2'b00, r_xpos} + {{5{w_dx[8]}}, w_dx};
  assign w_ny = {2'b00, r_ypos} - {{5{w_dy[8]}}, w_dy};

  always_comb begin
    w_x_clamped = w_nx[11:0];
    if (w_nx[13])
      w_x_clamped = 12'd0;
    else if (w_nx > 14'(XMAX))
      w_x_clamped = 12'(XMAX);
  end

  always_comb begin
    w_y_clamped = w_ny[11:0];
    if (w_ny[13])
      w_y_clamped = 12'd0;
    else if (w_ny > 14'(YMAX))
      w_y_clamped = 12'(YMAX);
  end

  always_comb begin
    w_state_next      = r_state;
    w_hdr_next        = r_hdr;
    w_b1_next         = r_b1;
    w_b2_next         = r_b2;
    w_timer_next      = r_timer;
    w_xpos_next       = r_xpos;
    w_ypos_next       = r_ypos;
    w_left_next       = r_left;
    w_right_next      = r_right;
    w_pos_update_next = 1'b0;

    case (r_state)
      BYTE0: begin
        w_timer_next = '0;
        if (w_sync) begin
          w_hdr_next   = w_hdr_in;
          w_state_next = BYTE1;
        end
      end
      BYTE1: begin
        if (rx_valid) begin
          w_b1_next    = rx_data;
          w_timer_next = '0;
          w_state_next = BYTE2;
        end else if (r_timer == TIMER_LAST) begin
          w_timer_next = '0;
          w_state_next = BYTE0;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      BYTE2: begin
        if (rx_valid) begin
          w_b2_next    = rx_data;
          w_timer_next = '0;
          w_state_next = APPLY;
        end else if (r_timer == TIMER_LAST) begin
          w_timer_next = '0;
          w_state_next = BYTE0;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      APPLY: begin
        w_xpos_next       = w_x_clamped;
        w_ypos_next       = w_y_clamped;
        w_left_next       = r_hdr.btn_l;
        w_right_next      = r_hdr.btn_r;
        w_pos_update_next = 1'b1;
        w_timer_next      = '0;
        w_state_next      = BYTE0;
        // A header arriving during the apply cycle starts the next packet.
        if (w_sync) begin
          w_hdr_next   = w_hdr_in;
          w_state_next = BYTE1;
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= BYTE0;
      r_hdr        <= '0;
      r_b1         <= '0;
      r_b2         <= '0;
      r_timer      <= '0;
      r_xpos       <= 12'(XINIT);
      r_ypos       <= 12'(YINIT);
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_pos_update <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_hdr        <= w_hdr_next;
      r_b1         <= w_b1_next;
      r_b2         <= w_b2_next;
      r_timer      <= w_timer_next;
      r_xpos       <= w_xpos_next;
      r_ypos       <= w_ypos_next;
      r_left       <= w_left_next;
      r_right      <= w_right_next;
      r_pos_update <= w_pos_update_next;
    end
  end

  assign xpos        = r_xpos;
  assign ypos        = r_ypos;
  assign mouse_left  = r_left;
  assign mouse_right = r_right;
  assign pos_update  = r_pos_update;

endmodule
